add_1bit_bist_checker: RTL

Synthesizable self-test sequencer for the mapped `add_1bit` fabric (`c = a ^ b`). It drives stimulus onto the DUT's `a`/`b` inputs and samples `c` after a programmable settle time. Each sample is compared against a golden XOR, and mismatches are counted. It sits beside `add_1bit_top_formal_verification` on the bitstream bench, or on silicon as an on-fabric BIST, so checking needs no simulator `$display` flow.

---
 rtl/add_1bit_bist_pkg.sv | 34 +++
 rtl/add_1bit_bist_checker_if.sv | 34 +++
 rtl/add_1bit_bist_lfsr.sv | 40 ++++
 rtl/add_1bit_bist_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/add_1bit_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_1bit_bist_pkg
// Brief    : Shared types, LFSR constants and helpers for the add_1bit BIST.
// Revision : 1.0 - initial release
// ============================================================================
package add_1bit_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_APPLY = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam int              ERR_W     = 8;
    localparam logic [ERR_W-1:0] ERR_MAX  = 8'hFF;

    localparam int               LFSR_W    = 8;
    // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], lfsr_fb(s)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_1bit_bist_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : add_1bit_bist_checker_if
// Brief    : Control, stimulus and result bundle of the add_1bit BIST checker.
// Revision : 1.0 - initial release
// ============================================================================
interface add_1bit_bist_checker_if;
    import add_1bit_bist_pkg::*;

    logic             start;
    logic             c_i;
    logic             a_o;
    logic             b_o;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             err_seen;
    logic [ERR_W-1:0] first_err_idx;

    // Host / DUT-fabric side
    modport master (
        output start, c_i,
        input  a_o, b_o, busy, done, pass, err_cnt, err_seen, first_err_idx
    );

    // Checker side
    modport slave (
        input  start, c_i,
        output a_o, b_o, busy, done, pass, err_cnt, err_seen, first_err_idx
    );

endinterface
`default_nettype wire

// File: rtl/add_1bit_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : add_1bit_bist_lfsr
// Brief    : 8-bit Fibonacci LFSR vector source; load has priority over step.
// Revision : 1.0 - initial release
// ============================================================================
module add_1bit_bist_lfsr
    import add_1bit_bist_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load,
    input  wire logic              step,
    output logic [LFSR_W-1:0]      q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/add_1bit_bist_checker.sv
`default_nettype none
// ============================================================================
// Module   : add_1bit_bist_checker
// Brief    : BIST sequencer for the add_1bit fabric (c = a ^ b). Vector source
//            is k[1:0] by default, or an LFSR with ADD_1BIT_BIST_LFSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module add_1bit_bist_checker
    import add_1bit_bist_pkg::*;
#(
    parameter int N_VECTORS     = 8,
    parameter int LEAD_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    add_1bit_bist_checker_if.slave bus
);

    localparam int CNT_W       = 16;
    localparam int LEAD_LAST   = (LEAD_CYCLES   > 0) ? LEAD_CYCLES - 1   : 0;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;
    // With a single settle cycle the vector goes straight to CHECK.
    localparam bist_state_e VEC_ENTRY = (SETTLE_CYCLES > 1) ? ST_APPLY : ST_CHECK;

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       k_q, k_d;
    logic             a_o_q, a_o_d, b_o_q, b_o_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_seen_q, err_seen_d;
    logic [ERR_W-1:0] first_err_idx_q, first_err_idx_d;

    logic [1:0] first_vec;
    logic [1:0] next_vec;
    logic       start_ok;
    logic       mismatch;

    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign mismatch = bus.c_i ^ (a_o_q ^ b_o_q);

`ifdef ADD_1BIT_BIST_LFSR_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_load;
    logic              lfsr_step;

    assign lfsr_load = start_ok;
    assign lfsr_step = (state_q == ST_CHECK);

    add_1bit_bist_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    // {a,b} = {q[0], q[1]}; next_vec is taken from the state after the step.
    assign first_vec = {LFSR_SEED[0], LFSR_SEED[1]};
    assign next_vec  = {lfsr_fb(lfsr_q), lfsr_q[0]};
`else
    assign first_vec = 2'b00;
    assign next_vec  = k_q[1:0] + 2'd1;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        k_d             = k_q;
        a_o_d           = a_o_q;
        b_o_d           = b_o_q;
        err_cnt_d       = err_cnt_q;
        err_seen_d      = err_seen_q;
        first_err_idx_d = first_err_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    cnt_d           = '0;
                    k_d             = '0;
                    err_cnt_d       = '0;
                    err_seen_d      = 1'b0;
                    first_err_idx_d = '0;
                    if (LEAD_CYCLES > 0) begin
                        state_d = ST_LEAD;
                        a_o_d   = 1'b0;
                        b_o_d   = 1'b0;
                    end else begin
                        state_d        = VEC_ENTRY;
                        {a_o_d, b_o_d} = first_vec;
                    end
                end
            end
            ST_LEAD: begin
                if (cnt_q == CNT_W'(LEAD_LAST)) begin
                    cnt_d          = '0;
                    state_d        = VEC_ENTRY;
                    {a_o_d, b_o_d} = first_vec;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_APPLY: begin
                if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!err_seen_q) begin
                        err_seen_d      = 1'b1;
                        first_err_idx_d = k_q;
                    end
                end
                if (k_q == 8'(N_VECTORS - 1)) begin
                    state_d = ST_DONE;
                    a_o_d   = 1'b0;
                    b_o_d   = 1'b0;
                end else begin
                    k_d            = k_q + 1'b1;
                    state_d        = VEC_ENTRY;
                    {a_o_d, b_o_d} = next_vec;
                end
            end
            default: begin
                state_d = ST_IDLE;
                a_o_d   = 1'b0;
                b_o_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_LEAD) || (state_d == ST_APPLY) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            k_q             <= '0;
            a_o_q           <= 1'b0;
            b_o_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_cnt_q       <= '0;
            err_seen_q      <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            k_q             <= k_d;
            a_o_q           <= a_o_d;
            b_o_q           <= b_o_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_cnt_q       <= err_cnt_d;
            err_seen_q      <= err_seen_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign bus.a_o           = a_o_q;
    assign bus.b_o           = b_o_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = done_q && (err_cnt_q == '0);
    assign bus.err_cnt       = err_cnt_q;
    assign bus.err_seen      = err_seen_q;
    assign bus.first_err_idx = first_err_idx_q;

endmodule
`default_nettype wire
